// File: rtl/pipeline_trace_buffer_if.sv
// Control, sample and readout bundle for pipeline_trace_buffer.
// slave = trace buffer side, master = core/debug side.
interface pipeline_trace_buffer_if #(
   parameter int DEPTH = 16,
   parameter int CYC_W = 16
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = CYC_W + 102;

   logic               arm;
   logic               force_trig;
   logic               trig_pc_en;
   logic [31:0]        trig_pc;
   logic [PTR_W:0]     post_count;
   logic [CYC_W-1:0]   cycle_limit;
   logic [31:0]        if_pc;
   logic [31:0]        id_instr;
   logic               wb_reg_write;
   logic [4:0]         wb_dest;
   logic [31:0]        wb_data;
   logic               rd_en;
   logic [PTR_W-1:0]   rd_idx;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;
   logic [1:0]         state;
   logic               triggered;
   logic [PTR_W:0]     entries;
   logic [CYC_W-1:0]   cycle_count;
   logic               halt_req;

   modport master (
      output arm, force_trig, trig_pc_en, trig_pc, post_count, cycle_limit,
             if_pc, id_instr, wb_reg_write, wb_dest, wb_data, rd_en, rd_idx,
      input  rd_data, rd_valid, state, triggered, entries, cycle_count, halt_req
   );

   modport slave (
      input  arm, force_trig, trig_pc_en, trig_pc, post_count, cycle_limit,
             if_pc, id_instr, wb_reg_write, wb_dest, wb_data, rd_en, rd_idx,
      output rd_data, rd_valid, state, triggered, entries, cycle_count, halt_req
   );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular trace capture (PC / IF-ID instr / WB write) with PC or forced trigger,
// post-trigger window and cycle-limit halt. Optional macro TRACE_WB_FILTER_EN.
module pipeline_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CYC_W = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   pipeline_trace_buffer_if.slave bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = CYC_W + 102;
   localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
   logic [PTR_W:0]     entries_q, entries_d;
   logic               triggered_q, triggered_d;
   logic               halt_req_q, halt_req_d;
   logic [CYC_W-1:0]   cycle_q, cycle_d;
   logic               rd_valid_q, rd_valid_d;
   logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] wr_entry;
   logic [PTR_W-1:0]   rd_addr;
   logic               wr_en;
   logic               keep;
   logic               trig_hit;

`ifdef TRACE_WB_FILTER_EN
   assign keep = bus.wb_reg_write && (bus.wb_dest != 5'd0);
`else
   assign keep = 1'b1;
`endif

   assign trig_hit = bus.force_trig || (bus.trig_pc_en && (bus.if_pc == bus.trig_pc));
   assign wr_entry = {cycle_q, bus.if_pc, bus.id_instr, bus.wb_reg_write, bus.wb_dest, bus.wb_data};
   // Oldest entry sits entries_q slots behind the write pointer; wraps naturally.
   assign rd_addr  = wr_ptr_q - entries_q[PTR_W-1:0] + bus.rd_idx;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      post_cnt_d  = post_cnt_q;
      entries_d   = entries_q;
      triggered_d = triggered_q;
      wr_en       = 1'b0;
      cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + CYC_W'(1);
      halt_req_d  = halt_req_q ||
                    ((bus.cycle_limit != '0) && (cycle_q == bus.cycle_limit));

      if (bus.arm) begin
         state_d     = ARMED;
         wr_ptr_d    = '0;
         entries_d   = '0;
         triggered_d = 1'b0;
         post_cnt_d  = '0;
      end else if ((state_q == ARMED) || (state_q == POST)) begin
         wr_en = keep;
         if (keep) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (entries_q != FULL) entries_d = entries_q + (PTR_W + 1)'(1);
         end
         if (state_q == ARMED) begin
            if (trig_hit) begin
               triggered_d = 1'b1;
               if (bus.post_count == '0) begin
                  state_d = DONE;
               end else begin
                  state_d    = POST;
                  post_cnt_d = (bus.post_count > {1'b0, LAST}) ? LAST
                                                               : bus.post_count[PTR_W-1:0];
               end
            end
         end else if (keep) begin
            post_cnt_d = post_cnt_q - PTR_W'(1);
            if (post_cnt_q == PTR_W'(1)) state_d = DONE;
         end
      end

      rd_valid_d = bus.rd_en && ({1'b0, bus.rd_idx} < entries_q);
      rd_data_d  = rd_valid_d ? mem_q[rd_addr] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         post_cnt_q  <= '0;
         entries_q   <= '0;
         triggered_q <= 1'b0;
         halt_req_q  <= 1'b0;
         cycle_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         post_cnt_q  <= post_cnt_d;
         entries_q   <= entries_d;
         triggered_q <= triggered_d;
         halt_req_q  <= halt_req_d;
         cycle_q     <= cycle_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Trace RAM is not reset; entries_q masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign bus.state       = state_q;
   assign bus.triggered   = triggered_q;
   assign bus.entries     = entries_q;
   assign bus.cycle_count = cycle_q;
   assign bus.halt_req    = halt_req_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_pipeline_trace_buffer;
   localparam int DEPTH   = 16;
   localparam int CYC_W   = 8;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = CYC_W + 102;
   localparam int unsigned CMAX = (1 << CYC_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   pipeline_trace_buffer_if #(.DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();

   pipeline_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: trace is a queue holding at most DEPTH samples, oldest first.
   logic [ENTRY_W-1:0] m_q[$];
   int unsigned        m_state, m_left, m_cycle;
   bit                 m_trig, m_halt, m_rd_valid;
   logic [ENTRY_W-1:0] m_rd_data;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_state = 0; m_left = 0; m_cycle = 0;
      m_trig = 0; m_halt = 0; m_rd_valid = 0; m_rd_data = '0;
   endtask

   task automatic model_edge();
      bit keep;
      bit hit;
      logic [ENTRY_W-1:0] s;
`ifdef TRACE_WB_FILTER_EN
      keep = bus.wb_reg_write && (bus.wb_dest != 5'd0);
`else
      keep = 1'b1;
`endif
      hit = bus.force_trig || (bus.trig_pc_en && (bus.if_pc == bus.trig_pc));
      m_rd_valid = bus.rd_en && (int'(bus.rd_idx) < m_q.size());
      m_rd_data  = m_rd_valid ? m_q[bus.rd_idx] : '0;
      s = {CYC_W'(m_cycle), bus.if_pc, bus.id_instr, bus.wb_reg_write, bus.wb_dest, bus.wb_data};
      if (bus.cycle_limit != 0 && m_cycle == int'(bus.cycle_limit)) m_halt = 1;
      if (m_cycle != CMAX) m_cycle++;
      if (bus.arm) begin
         m_state = 1; m_q.delete(); m_trig = 0;
      end else if (m_state == 1 || m_state == 2) begin
         if (keep) begin
            m_q.push_back(s);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
         end
         if (m_state == 1) begin
            if (hit) begin
               m_trig = 1;
               if (bus.post_count == 0) m_state = 3;
               else begin
                  m_state = 2;
                  m_left  = (int'(bus.post_count) > DEPTH - 1) ? DEPTH - 1 : int'(bus.post_count);
               end
            end
         end else if (keep) begin
            m_left--;
            if (m_left == 0) m_state = 3;
         end
      end
   endtask

   task automatic check_outputs();
      chk("state",       128'(bus.state),       128'(m_state));
      chk("triggered",   128'(bus.triggered),   128'(m_trig));
      chk("entries",     128'(bus.entries),     128'(m_q.size()));
      chk("cycle_count", 128'(bus.cycle_count), 128'(m_cycle));
      chk("halt_req",    128'(bus.halt_req),    128'(m_halt));
      chk("rd_valid",    128'(bus.rd_valid),    128'(m_rd_valid));
      chk("rd_data",     128'(bus.rd_data),     128'(m_rd_data));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
      bus.arm = 1'b0;
      bus.force_trig = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [ENTRY_W-1:0] e;
      int unsigned c0;
      bit          fw [6];
      logic [4:0]  fd [6];
      fw = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      fd = '{5'd9, 5'd0, 5'd3, 5'd10, 5'd9, 5'd4};

      bus.arm = 0; bus.force_trig = 0; bus.trig_pc_en = 0; bus.trig_pc = '0;
      bus.post_count = '0; bus.cycle_limit = '0; bus.if_pc = '0; bus.id_instr = '0;
      bus.wb_reg_write = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = '0;
      bus.rd_en = 0; bus.rd_idx = '0;
      #2;
      do_reset();

      // cycle-limit halt
      bus.cycle_limit = CYC_W'(6);
      for (int i = 0; i < 6; i++) step();
      chk("halt_before_limit", 128'(bus.halt_req), 128'(0));
      step();
      chk("halt_at_limit", 128'(bus.halt_req), 128'(1));
      chk("halt_cycle", 128'(bus.cycle_count), 128'(7));

      // PC-match trigger with post window of 2
      bus.arm = 1'b1;
      step();
      chk("arm_state", 128'(bus.state), 128'(1));
      bus.trig_pc_en = 1'b1; bus.trig_pc = 32'd8; bus.post_count = (PTR_W + 1)'(2);
      c0 = m_cycle;
      for (int i = 0; i < 5; i++) begin
         bus.if_pc = 32'(4 * i); bus.id_instr = $urandom; bus.wb_data = $urandom;
         step();
      end
      chk("pcm_done", 128'(bus.state), 128'(3));
      chk("pcm_entries", 128'(bus.entries), 128'(5));
      chk("pcm_halt_kept", 128'(bus.halt_req), 128'(1));
      bus.trig_pc_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.rd_en = 1'b1; bus.rd_idx = PTR_W'(i);
         step();
         e = bus.rd_data;
         chk("pcm_rd_pc", 128'(e[101:70]), 128'(4 * i));
         chk("pcm_rd_cycle", 128'(e[ENTRY_W-1:102]), 128'(c0 + i));
      end

      // reset in the middle of POST
      bus.arm = 1'b1;
      step();
      bus.force_trig = 1'b1; bus.post_count = (PTR_W + 1)'(8);
      step();
      bus.rd_en = 1'b1; bus.rd_idx = '0;
      step();
      chk("mid_post_state", 128'(bus.state), 128'(2));
      do_reset();
      chk("rst_state", 128'(bus.state), 128'(0));
      chk("rst_entries", 128'(bus.entries), 128'(0));
      chk("rst_triggered", 128'(bus.triggered), 128'(0));
      chk("rst_halt", 128'(bus.halt_req), 128'(0));

      // wrap: 20 ARMED samples then forced trigger, no post window
      bus.arm = 1'b1; bus.post_count = '0;
      step();
      for (int k = 0; k < 20; k++) begin
         bus.if_pc = 32'(100 + 4 * k);
         step();
      end
      bus.if_pc = 32'd180; bus.force_trig = 1'b1;
      step();
      chk("wrap_done", 128'(bus.state), 128'(3));
      chk("wrap_entries", 128'(bus.entries), 128'(16));
      bus.rd_en = 1'b1; bus.rd_idx = '0;
      step();
      chk("wrap_oldest_pc", 128'(bus.rd_data[101:70]), 128'(120));
      bus.if_pc = 32'd200;
      for (int k = 0; k < 3; k++) step();
      bus.rd_en = 1'b1; bus.rd_idx = PTR_W'(15);
      step();
      chk("wrap_newest_pc", 128'(bus.rd_data[101:70]), 128'(180));
      chk("wrap_entries_held", 128'(bus.entries), 128'(16));

      // arm and trigger on the same edge: arm wins
      bus.arm = 1'b1;
      step();
      step();
      bus.arm = 1'b1; bus.force_trig = 1'b1;
      step();
      chk("arm_win_state", 128'(bus.state), 128'(1));
      chk("arm_win_trig", 128'(bus.triggered), 128'(0));
      chk("arm_win_entries", 128'(bus.entries), 128'(0));
      bus.rd_en = 1'b1; bus.rd_idx = '0;
      step();
      chk("arm_win_rd_valid", 128'(bus.rd_valid), 128'(0));
      chk("arm_win_rd_data", 128'(bus.rd_data), 128'(0));

      // writeback filter pattern
      bus.arm = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         bus.wb_reg_write = fw[i]; bus.wb_dest = fd[i];
         step();
      end
`ifdef TRACE_WB_FILTER_EN
      chk("filt_entries", 128'(bus.entries), 128'(3));
      bus.wb_reg_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.rd_en = 1'b1; bus.rd_idx = PTR_W'(i);
         step();
         chk("filt_dest", 128'(bus.rd_data[36:32]), 128'((i == 1) ? 10 : 9));
      end
`else
      chk("nofilt_entries", 128'(bus.entries), 128'(6));
`endif
      bus.wb_reg_write = 1'b1; bus.wb_dest = 5'd5;

      // random traffic
      for (int n = 0; n < 700; n++) begin
         bus.arm          = ($urandom_range(0, 39) == 0);
         bus.force_trig   = ($urandom_range(0, 29) == 0);
         bus.trig_pc_en   = 1'($urandom_range(0, 1));
         bus.trig_pc      = 32'(4 * $urandom_range(0, 15));
         bus.if_pc        = 32'(4 * $urandom_range(0, 15));
         bus.post_count   = (PTR_W + 1)'($urandom_range(0, 2 * DEPTH - 1));
         bus.id_instr     = $urandom;
         bus.wb_reg_write = 1'($urandom_range(0, 1));
         bus.wb_dest      = 5'($urandom_range(0, 31));
         bus.wb_data      = $urandom;
         bus.rd_en        = 1'($urandom_range(0, 1));
         bus.rd_idx       = PTR_W'($urandom_range(0, DEPTH - 1));
         step();
      end
      chk("cycle_saturated", 128'(bus.cycle_count), 128'(CMAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
